// File: rtl/rf_write_arbiter.sv
// Write-port controller for the 32x32 register file: round-robin arbitration
// between ALU and load writeback, plus a full-file clear sweep.
module rf_write_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state, state_next;
  logic              last_grant;
  logic [ADDR_W-1:0] clr_cnt;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              grant0, grant1;

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state)
      ARB: begin
        if (clear_start) begin
          state_next = CLEAR;
        end else if (req0_valid && req1_valid) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
      end
      CLEAR: begin
        if (clr_cnt == '1) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  // Readies are masked by rst so nothing is accepted while reset is held.
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      last_grant <= 1'b1;
      clr_cnt    <= '0;
      wb_we      <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
    end else begin
      state <= state_next;
      wb_we <= 1'b0;
      if (grant0) begin
        last_grant <= 1'b0;
        wb_we      <= |req0_addr;
        wb_addr    <= req0_addr;
        wb_data    <= req0_data;
      end else if (grant1) begin
        last_grant <= 1'b1;
        wb_we      <= |req1_addr;
        wb_addr    <= req1_addr;
        wb_data    <= req1_data;
      end
      if (state == CLEAR) clr_cnt <= clr_cnt + ADDR_W'(1);
      else                clr_cnt <= '0;
    end
  end

  // Sweep writes are driven straight from the counter so reset aborts them at once.
  assign clear_busy = (state == CLEAR);
  assign rf_we      = wb_we || clear_busy;
  assign rf_waddr   = clear_busy ? clr_cnt : wb_addr;
  assign rf_wdata   = clear_busy ? '0 : wb_data;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed + random bench for rf_write_arbiter: reference arbitration model,
// write scoreboard queue and a behavioural register file fed by the DUT.
module tb_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, rf_waddr;
  logic [DW-1:0] req0_data, req1_data, rf_wdata;
  logic          clear_start, clear_busy, rf_we;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] rf_mem [32];
  logic          m_last = 1'b1;
  int            m_clear = 0;
  logic          g0, g1, s_r0, s_r1;
  int            wait0, wait1;

  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every DUT write must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 64'(rf_waddr), 64'hFFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 64'(rf_waddr), 64'(e.addr));
        check("write_data", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    check("clear_busy", 64'(clear_busy), 64'(m_clear != 0));
    if (m_clear != 0) begin
      m_clear--;
    end else if (clear_start) begin
      m_clear = 32;
      for (int i = 0; i < 32; i++) exp_q.push_back({AW'(i), DW'(0)});
    end else begin
      if (req0_valid && req1_valid) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      if (g0) begin
        m_last = 1'b0;
        if (req0_addr != 0) exp_q.push_back({req0_addr, req0_data});
      end else if (g1) begin
        m_last = 1'b1;
        if (req1_addr != 0) exp_q.push_back({req1_addr, req1_data});
      end
    end
    check("req0_ready", 64'(s_r0), 64'(g0));
    check("req1_ready", 64'(s_r1), 64'(g1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clear_start = 1'b0;
    exp_q.delete();
    m_last = 1'b1;
    m_clear = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      req0_valid = 1'b1;
      req0_addr  = AW'(i);
      req0_data  = 32'hA500_0000 | DW'(i);
      step();
    end
    req0_valid = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;
    rst = 1'b1;
    clear_start = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h2;
    #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_rf_wdata", 64'(rf_wdata), 64'd0);
    check("rst_clear_busy", 64'(clear_busy), 64'd0);
    check("rst_req0_ready", 64'(req0_ready), 64'd0);
    check("rst_req1_ready", 64'(req1_ready), 64'd0);
    do_reset();

    // Single write to register 5
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    step();
    check("t1_ready", 64'(s_r0), 64'd1);
    req0_valid = 1'b0;
    check("t1_rf_we", 64'(rf_we), 64'd1);
    check("t1_rf_waddr", 64'(rf_waddr), 64'd5);
    check("t1_rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    step();
    check("t1_reg5", 64'(rf_mem[5]), 64'hDEAD_BEEF);

    // Continuous contention after reset: req0, req1, req0, req1
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_00A1;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_00B2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_req0", 64'(s_r0), 64'(i % 2 == 0));
      check("rr_req1", 64'(s_r1), 64'(i % 2 == 1));
      check("rr_waddr", 64'(rf_waddr), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Write to register 0 is accepted but suppressed
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1234;
    step();
    check("a0_ready", 64'(s_r1), 64'd1);
    req1_valid = 1'b0;
    check("a0_rf_we", 64'(rf_we), 64'd0);
    step();
    check("a0_reg0", 64'(rf_mem[0]), 64'd0);

    // Full clear sweep with req0 pending
    preload();
    check("pre_reg17", 64'(rf_mem[17]), 64'hA500_0011);
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    clear_start = 1'b1;
    step();
    check("clr_ready_n", 64'(s_r0), 64'd0);
    clear_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("clr_sweep_addr", 64'(rf_waddr), 64'(i));
      step();
    end
    for (int i = 0; i < 32; i++) check("clr_reg_zero", 64'(rf_mem[i]), 64'd0);
    step();
    check("clr_resume_grant", 64'(s_r0), 64'd1);
    req0_valid = 1'b0;
    step();

    // Reset in the middle of a sweep
    preload();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (10) step();
    check("abort_at10", 64'(rf_waddr), 64'd10);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    rst = 1'b1;
    exp_q.delete();
    m_last = 1'b1;
    m_clear = 0;
    #1;
    check("abort_rf_we", 64'(rf_we), 64'd0);
    check("abort_rf_waddr", 64'(rf_waddr), 64'd0);
    check("abort_rf_wdata", 64'(rf_wdata), 64'd0);
    check("abort_busy", 64'(clear_busy), 64'd0);
    check("abort_ready0", 64'(req0_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 1; i < 10; i++) check("abort_swept", 64'(rf_mem[i]), 64'd0);
    for (int i = 11; i < 32; i++) check("abort_kept", 64'(rf_mem[i]), 64'(32'hA500_0000 | i));
    step();
    check("abort_first_req0", 64'(s_r0), 64'd1);
    check("abort_first_req1", 64'(s_r1), 64'd0);
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b0;
    step();

    // Random traffic on both ports
    wait0 = 0;
    wait1 = 0;
    for (int c = 0; c < 10000; c++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_addr = AW'($urandom); req0_data = $urandom;
      end
      if (!req1_valid && $urandom_range(0, 2) != 0) begin
        req1_valid = 1'b1; req1_addr = AW'($urandom); req1_data = $urandom;
      end
      step();
      if (g0) begin
        check("wait0_bound", 64'(wait0 <= 1), 64'd1);
        req0_valid = 1'b0;
        wait0 = 0;
      end else if (req0_valid) wait0++;
      if (g1) begin
        check("wait1_bound", 64'(wait1 <= 1), 64'd1);
        req1_valid = 1'b0;
        wait1 = 0;
      end else if (req1_valid) wait1++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port controller for the 32×32 register file. Shares the single write port between two writeback requesters (req0: ALU writeback, req1: memory-load writeback) using round-robin arbitration with valid/ready handshakes. Also sequences a full-file clear sweep on command. Sits between the writeback stage and the register file's WriteEn/WriteAddr/WriteData inputs.

## Interface
Parameters:
- DATA_W, 32, data width of register file words
- ADDR_W, 5, register address width (file depth = 2^ADDR_W = 32)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_addr  input  ADDR_W  requester 0 destination register
- req0_data  input  DATA_W  requester 0 write data
- req0_ready  output  1  requester 0 write accepted this cycle
- req1_valid / req1_addr / req1_data / req1_ready  same as req0, for requester 1
- clear_start  input  1  single-cycle pulse: zero all 32 registers
- clear_busy  output  1  clear sweep in progress
- rf_we  output  1  to register file WriteEn
- rf_waddr  output  ADDR_W  to register file WriteAddr
- rf_wdata  output  DATA_W  to register file WriteData

## Operation
- States: ARB (normal arbitration), CLEAR (sweep). Reset state ARB.
- Internal `last_grant` bit (reset 1, so req0 wins the first contention).
- ARB, clear_start=0:
  - only req0_valid → req0_ready=1; only req1_valid → req1_ready=1.
  - both valid → grant requester ≠ last_grant; other ready=0.
  - neither → both ready=0.
  - on grant, last_grant ← granted index; with no grant last_grant holds.
  - readies are combinational from valids, state, clear_start, last_grant.
- Handshake: transfer occurs when valid && ready in the same cycle. Requester holds valid/addr/data stable until ready; arbiter never drops a held valid permanently (round-robin bounds wait to 1 grant).
- Granted transfer: next cycle rf_we=1, rf_waddr=addr, rf_wdata=data. Exception: addr==0 → handshake completes, rf_we=0 (register 0 is read-only zero from writeback).
- clear_start=1 in ARB: both readies forced 0 that cycle; enter CLEAR; 5-bit sweep counter ← 0.
- CLEAR: each cycle rf_we=1, rf_waddr=counter, rf_wdata=0, counter+1; after address 31 return to ARB. Sweep does write register 0. Readies 0 throughout. clear_start during CLEAR ignored. last_grant unchanged by CLEAR.
- rf_we is 0 on any cycle without a registered write.

## Timing
- Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, clear_busy=0, state ARB, last_grant=1, counter 0. Readies 0 while rst high. Reset mid-sweep aborts the sweep; no further rf_we.
- Write latency: handshake at cycle N → rf_we/rf_waddr/rf_wdata valid during N+1 → register file updated at end of N+1. Throughput one write per cycle.
- Back-to-back grants to the same address: both written in order, later wins.
- clear_start at cycle N: readies 0 in N..N+32; clear_busy=1 in N+1..N+32; rf_we addr 0 at N+1 … addr 31 at N+32; arbitration resumes at N+33. A handshake granted at N−1 still writes at N (before the sweep).
- rf_waddr/rf_wdata hold last value when rf_we=0 (don't-care for consumer).

## Test plan
- Reset then req0 valid addr 5 data 0xDEADBEEF → req0_ready=1 same cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; register 5 reads 0xDEADBEEF.
- Both valid continuously (req0 addr 1, req1 addr 2) for 4 cycles → grants req0,req1,req0,req1; rf_waddr sequence 1,2,1,2 one cycle delayed.
- req1 valid addr 0 data 0x1234 → req1_ready=1, rf_we stays 0; register 0 still reads 0.
- Preload registers 1..31 nonzero, pulse clear_start with req0 valid → req0_ready=0 for 33 cycles, clear_busy high 32 cycles, rf_waddr 0..31 with data 0; all registers read 0; req0 granted on cycle N+33.
- Assert rst at sweep address 10 → outputs zero immediately, registers 11..31 keep preload values, after release req0 wins first contention.
- Random valid/addr/data on both ports 10k cycles vs. reference model: every handshake produces exactly one write (or none for addr 0), in order, no starvation beyond 1 cycle under contention.
